// File: rtl/i2c_pkg.sv
// Shared I2C timing defaults and line-drive encoding used by the master protocol stages.
package i2c_pkg;

  localparam int unsigned CLK_CYCLES      = 500;
  localparam int unsigned BUS_FREE_CYCLES = 470;
  localparam int unsigned TIMEOUT_CYCLES  = 100000;

  // Open-drain enables: 0 pulls the line low, 1 lets the pull-up win.
  localparam logic LINE_DRIVE_LOW = 1'b0;
  localparam logic LINE_RELEASE   = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_bus_free_detect.sv
// Watches both I2C lines while enabled and flags either a full bus-free window
// or a timeout, each as a registered one-cycle pulse.
module i2c_bus_free_detect #(
  parameter int unsigned BUS_FREE_CYCLES = 470,
  parameter int unsigned TIMEOUT_CYCLES  = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic scl_read,
  input  logic sda_read,
  output logic bus_free,
  output logic bus_timeout
);
  import i2c_pkg::*;

  localparam int FREE_W = cnt_width(BUS_FREE_CYCLES);
  localparam int TMO_W  = cnt_width(TIMEOUT_CYCLES);

  logic [FREE_W-1:0] free_cnt;
  logic [TMO_W-1:0]  timeout_cnt;
  logic              lines_high;
  logic              free_hit;
  logic              timeout_hit;

  assign lines_high  = scl_read & sda_read;
  assign free_hit    = lines_high && (free_cnt == FREE_W'(BUS_FREE_CYCLES - 1));
  assign timeout_hit = (timeout_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Any low sample restarts the window; a completed window beats a same-cycle timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_cnt    <= '0;
      timeout_cnt <= '0;
      bus_free    <= 1'b0;
      bus_timeout <= 1'b0;
    end else if (!enable) begin
      free_cnt    <= '0;
      timeout_cnt <= '0;
      bus_free    <= 1'b0;
      bus_timeout <= 1'b0;
    end else begin
      free_cnt    <= lines_high ? free_cnt + 1'b1 : '0;
      timeout_cnt <= timeout_cnt + 1'b1;
      bus_free    <= free_hit;
      bus_timeout <= timeout_hit & ~free_hit;
    end
  end

endmodule

// File: rtl/protocol_start.sv
// I2C master START generator: waits for a free bus, drops SDA while SCL is high,
// then pulls SCL low and hands the owned bus to the byte stages.
module protocol_start #(
  parameter int unsigned CLK_CYCLES      = i2c_pkg::CLK_CYCLES,
  parameter int unsigned BUS_FREE_CYCLES = i2c_pkg::BUS_FREE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = i2c_pkg::TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic start_flag,
  input  logic scl_read,
  input  logic sda_read,
  output logic scl_en,
  output logic sda_en,
  output logic complete,
  output logic error
);
  import i2c_pkg::*;

  localparam int CNT_W = cnt_width(CLK_CYCLES);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CHECK_BUS  = 3'd1,
    HOLD_START = 3'd2,
    SCL_LOW    = 3'd3,
    DONE       = 3'd4,
    ERROR      = 3'd5
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] clk_counter;
  logic [CNT_W-1:0] clk_counter_next;
  logic             scl_en_next;
  logic             sda_en_next;
  logic             complete_next;
  logic             error_next;
  logic             illegal_state;
  logic             bus_free;
  logic             bus_timeout;

  i2c_bus_free_detect #(
    .BUS_FREE_CYCLES(BUS_FREE_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_bus_free_detect (
    .clk        (clk),
    .reset      (reset),
    .enable     (state == CHECK_BUS),
    .scl_read   (scl_read),
    .sda_read   (sda_read),
    .bus_free   (bus_free),
    .bus_timeout(bus_timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      clk_counter <= '0;
      scl_en      <= LINE_RELEASE;
      sda_en      <= LINE_RELEASE;
      complete    <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= next_state;
      clk_counter <= clk_counter_next;
      scl_en      <= scl_en_next;
      sda_en      <= sda_en_next;
      complete    <= complete_next;
      error       <= error_next;
    end
  end

  // Outputs are decoded from the state being entered so they switch on the same edge.
  always_comb begin
    next_state       = state;
    clk_counter_next = '0;
    illegal_state    = 1'b0;
    scl_en_next      = scl_en;
    sda_en_next      = sda_en;
    complete_next    = 1'b0;
    error_next       = 1'b0;

    case (state)
      IDLE: begin
        if (start_flag) next_state = CHECK_BUS;
      end
      CHECK_BUS: begin
        if (bus_free)         next_state = HOLD_START;
        else if (bus_timeout) next_state = ERROR;
      end
      HOLD_START: begin
        if (!scl_read)                                   next_state = ERROR;
        else if (clk_counter == CNT_W'(CLK_CYCLES - 1))  next_state = SCL_LOW;
        else                                             clk_counter_next = clk_counter + 1'b1;
      end
      SCL_LOW: begin
        if (clk_counter == CNT_W'(CLK_CYCLES / 2 - 1)) next_state = DONE;
        else                                           clk_counter_next = clk_counter + 1'b1;
      end
      DONE:    next_state = IDLE;
      ERROR:   next_state = IDLE;
      default: begin
        next_state    = IDLE;
        illegal_state = 1'b1;
      end
    endcase

    case (next_state)
      CHECK_BUS: begin
        scl_en_next = LINE_RELEASE;
        sda_en_next = LINE_RELEASE;
      end
      HOLD_START: begin
        scl_en_next = LINE_RELEASE;
        sda_en_next = LINE_DRIVE_LOW;
      end
      SCL_LOW: begin
        scl_en_next = LINE_DRIVE_LOW;
        sda_en_next = LINE_DRIVE_LOW;
      end
      DONE: begin
        scl_en_next   = LINE_DRIVE_LOW;
        sda_en_next   = LINE_DRIVE_LOW;
        complete_next = 1'b1;
      end
      ERROR: begin
        scl_en_next = LINE_RELEASE;
        sda_en_next = LINE_RELEASE;
        error_next  = 1'b1;
      end
      default: begin
      end
    endcase

    // A corrupted state register recovers with the bus released.
    if (illegal_state) begin
      scl_en_next = LINE_RELEASE;
      sda_en_next = LINE_RELEASE;
    end
  end

endmodule

// File: tb/tb_protocol_start.sv
// Randomized self-checking bench for protocol_start; expected event times come from
// a bus-free-window / hold-time model of the START sequence.
module tb_protocol_start;

  localparam int CLK_CYC  = 500;
  localparam int BUS_FREE = 470;
  localparam int TIMEOUT  = 2000;
  localparam int MAXC     = 4096;

  logic clk;
  logic reset;
  logic start_flag;
  logic scl_ext;
  logic sda_ext;
  logic scl_read;
  logic sda_read;
  logic scl_en;
  logic sda_en;
  logic complete;
  logic error;

  int checks = 0;
  int errors = 0;

  // Per-cycle external pull-down schedule, indexed by cycles after the sampling edge.
  bit scl_low [0:MAXC-1];
  bit sda_low [0:MAXC-1];

  int obs_sda, obs_scl, obs_cmp, obs_err, n_cmp, n_err;
  logic [1:0] cmp_en, err_en;

  // Wired-AND open-drain bus.
  assign scl_read = scl_en & scl_ext;
  assign sda_read = sda_en & sda_ext;

  protocol_start #(
    .CLK_CYCLES     (CLK_CYC),
    .BUS_FREE_CYCLES(BUS_FREE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_flag(start_flag),
    .scl_read  (scl_read),
    .sda_read  (sda_read),
    .scl_en    (scl_en),
    .sda_en    (sda_en),
    .complete  (complete),
    .error     (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_schedule;
    foreach (scl_low[i]) begin
      scl_low[i] = 1'b0;
      sda_low[i] = 1'b0;
    end
  endtask

  task automatic add_glitch(input int pos, input bit on_scl, input int len);
    for (int i = 0; i < len; i++) begin
      if (pos + i < MAXC) begin
        if (on_scl) scl_low[pos + i] = 1'b1;
        else        sda_low[pos + i] = 1'b1;
      end
    end
  endtask

  // Attempt starting at edge 'off': find the first 470-cycle run of both-high samples
  // within the timeout window, then the 500-cycle hold and 250-cycle SCL-low phases.
  function automatic void predict(input int off, output int e_sda, output int e_scl,
                                  output int e_cmp, output int e_err);
    int run = 0;
    int free_at = -1;
    e_sda = -1; e_scl = -1; e_cmp = -1; e_err = -1;
    for (int c = 0; c < TIMEOUT; c++) begin
      if (!scl_low[off + c] && !sda_low[off + c]) run++;
      else run = 0;
      if (run == BUS_FREE) begin
        free_at = c;
        break;
      end
    end
    if (free_at < 0) begin
      e_err = off + TIMEOUT + 1;
      return;
    end
    e_sda = off + free_at + 2;
    for (int k = 0; k < CLK_CYC; k++) begin
      if (scl_low[e_sda + k]) begin
        e_err = e_sda + k + 1;
        return;
      end
    end
    e_scl = e_sda + CLK_CYC;
    e_cmp = e_scl + CLK_CYC / 2;
  endfunction

  // Drives one request and records the edge of every observed event (edge 0 = sampling edge).
  task automatic run_attempt(input int max_edges, input bit hold_req);
    bit err_seen = 1'b0;
    logic prev_sda = 1'b1;
    logic prev_scl = 1'b1;
    obs_sda = -1; obs_scl = -1; obs_cmp = -1; obs_err = -1;
    n_cmp = 0; n_err = 0; cmp_en = 2'bxx; err_en = 2'bxx;
    start_flag = 1'b1;
    scl_ext = 1'b1;
    sda_ext = 1'b1;
    for (int e = 0; e <= max_edges && e < MAXC; e++) begin
      @(posedge clk); #1;
      if (e > 0 && prev_sda === 1'b1 && sda_en === 1'b0 && obs_sda < 0) obs_sda = e;
      if (e > 0 && prev_scl === 1'b1 && scl_en === 1'b0 && obs_scl < 0) obs_scl = e;
      if (complete === 1'b1) begin
        n_cmp++;
        if (obs_cmp < 0) begin obs_cmp = e; cmp_en = {scl_en, sda_en}; end
      end
      if (error === 1'b1) begin
        n_err++;
        err_seen = 1'b1;
        if (obs_err < 0) begin obs_err = e; err_en = {scl_en, sda_en}; end
      end
      prev_sda = sda_en;
      prev_scl = scl_en;
      scl_ext = !scl_low[e];
      sda_ext = !sda_low[e];
      start_flag = hold_req && !err_seen;
    end
    start_flag = 1'b0;
    scl_ext = 1'b1;
    sda_ext = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++; if (scl_en !== 1'b1) begin errors++; $display("[TB] FAIL reset scl_en: got %b want 1", scl_en); end
    checks++; if (sda_en !== 1'b1) begin errors++; $display("[TB] FAIL reset sda_en: got %b want 1", sda_en); end
    checks++; if (complete !== 1'b0) begin errors++; $display("[TB] FAIL reset complete: got %b want 0", complete); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset error: got %b want 0", error); end
  endtask

  task automatic test_idle_bus;
    clear_schedule();
    run_attempt(1225, 1'b0);
    checks++; if (obs_sda != 471) begin errors++; $display("[TB] FAIL idle sda_fall: got %0d want 471", obs_sda); end
    checks++; if (obs_scl != 971) begin errors++; $display("[TB] FAIL idle scl_fall: got %0d want 971", obs_scl); end
    checks++; if (obs_cmp != 1221) begin errors++; $display("[TB] FAIL idle complete: got %0d want 1221", obs_cmp); end
    checks++; if (n_cmp != 1) begin errors++; $display("[TB] FAIL idle complete_count: got %0d want 1", n_cmp); end
    checks++; if (n_err != 0) begin errors++; $display("[TB] FAIL idle error_count: got %0d want 0", n_err); end
    checks++; if (cmp_en !== 2'b00) begin errors++; $display("[TB] FAIL idle en_at_complete: got %b want 00", cmp_en); end
    checks++; if ({scl_en, sda_en} !== 2'b00) begin errors++; $display("[TB] FAIL idle en_held: got %b want 00", {scl_en, sda_en}); end
  endtask

  task automatic test_glitch;
    int e_sda, e_scl, e_cmp, e_err;
    clear_schedule();
    sda_low[299] = 1'b1;
    run_attempt(1525, 1'b0);
    checks++; if (obs_sda != 771) begin errors++; $display("[TB] FAIL glitch sda_fall: got %0d want 771", obs_sda); end
    checks++; if (obs_cmp != 1521) begin errors++; $display("[TB] FAIL glitch complete: got %0d want 1521", obs_cmp); end
    for (int it = 0; it < 3; it++) begin
      clear_schedule();
      add_glitch(int'($urandom_range(0, 1200)), 1'($urandom_range(0, 1)), 1);
      predict(0, e_sda, e_scl, e_cmp, e_err);
      run_attempt(((e_err >= 0) ? e_err : e_cmp) + 3, 1'b0);
      checks++; if (obs_sda != e_sda) begin errors++; $display("[TB] FAIL rglitch sda_fall: got %0d want %0d", obs_sda, e_sda); end
      checks++; if (obs_scl != e_scl) begin errors++; $display("[TB] FAIL rglitch scl_fall: got %0d want %0d", obs_scl, e_scl); end
      checks++; if (obs_cmp != e_cmp) begin errors++; $display("[TB] FAIL rglitch complete: got %0d want %0d", obs_cmp, e_cmp); end
      checks++; if (obs_err != e_err) begin errors++; $display("[TB] FAIL rglitch error: got %0d want %0d", obs_err, e_err); end
    end
  endtask

  task automatic test_stuck_line;
    clear_schedule();
    add_glitch(0, 1'b1, 2100);
    run_attempt(2004, 1'b0);
    checks++; if (obs_err != 2001) begin errors++; $display("[TB] FAIL stuck error: got %0d want 2001", obs_err); end
    checks++; if (n_cmp != 0) begin errors++; $display("[TB] FAIL stuck complete_count: got %0d want 0", n_cmp); end
    checks++; if (obs_sda != -1) begin errors++; $display("[TB] FAIL stuck sda_fall: got %0d want -1", obs_sda); end
    checks++; if (err_en !== 2'b11) begin errors++; $display("[TB] FAIL stuck en_at_error: got %b want 11", err_en); end
  endtask

  task automatic test_arbitration;
    int e_sda, e_scl, e_cmp, e_err;
    clear_schedule();
    scl_low[471 + 100] = 1'b1;
    run_attempt(575, 1'b0);
    checks++; if (obs_err != 572) begin errors++; $display("[TB] FAIL arb error: got %0d want 572", obs_err); end
    checks++; if (obs_scl != -1) begin errors++; $display("[TB] FAIL arb scl_fall: got %0d want -1", obs_scl); end
    checks++; if (n_cmp != 0) begin errors++; $display("[TB] FAIL arb complete_count: got %0d want 0", n_cmp); end
    checks++; if (err_en !== 2'b11) begin errors++; $display("[TB] FAIL arb en_at_error: got %b want 11", err_en); end
    for (int it = 0; it < 2; it++) begin
      clear_schedule();
      scl_low[471 + int'($urandom_range(0, CLK_CYC - 1))] = 1'b1;
      predict(0, e_sda, e_scl, e_cmp, e_err);
      run_attempt(((e_err >= 0) ? e_err : e_cmp) + 3, 1'b0);
      checks++; if (obs_err != e_err) begin errors++; $display("[TB] FAIL rarb error: got %0d want %0d", obs_err, e_err); end
      checks++; if (obs_cmp != e_cmp) begin errors++; $display("[TB] FAIL rarb complete: got %0d want %0d", obs_cmp, e_cmp); end
      checks++; if (err_en !== 2'b11) begin errors++; $display("[TB] FAIL rarb en_at_error: got %b want 11", err_en); end
    end
  endtask

  task automatic test_random_traffic;
    int e_sda, e_scl, e_cmp, e_err, n;
    for (int it = 0; it < 4; it++) begin
      clear_schedule();
      n = int'($urandom_range(0, 6));
      for (int g = 0; g < n; g++)
        add_glitch(int'($urandom_range(0, 2500)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
      predict(0, e_sda, e_scl, e_cmp, e_err);
      run_attempt(((e_err >= 0) ? e_err : e_cmp) + 3, 1'b0);
      checks++; if (obs_sda != e_sda) begin errors++; $display("[TB] FAIL rand sda_fall: got %0d want %0d", obs_sda, e_sda); end
      checks++; if (obs_scl != e_scl) begin errors++; $display("[TB] FAIL rand scl_fall: got %0d want %0d", obs_scl, e_scl); end
      checks++; if (obs_cmp != e_cmp) begin errors++; $display("[TB] FAIL rand complete: got %0d want %0d", obs_cmp, e_cmp); end
      checks++; if (obs_err != e_err) begin errors++; $display("[TB] FAIL rand error: got %0d want %0d", obs_err, e_err); end
    end
  endtask

  task automatic test_reset_mid_operation;
    int waited = 0;
    bit pulse_seen = 1'b0;
    clear_schedule();
    start_flag = 1'b1;
    @(posedge clk); #1;
    start_flag = 1'b0;
    while (scl_en !== 1'b0 && waited < 1500) begin
      @(posedge clk); #1;
      waited++;
      if (complete === 1'b1 || error === 1'b1) pulse_seen = 1'b1;
    end
    checks++; if (scl_en !== 1'b0) begin errors++; $display("[TB] FAIL rstmid reach_scl_low: got %b want 0", scl_en); end
    repeat (int'($urandom_range(1, 200))) begin
      @(posedge clk); #1;
      if (complete === 1'b1 || error === 1'b1) pulse_seen = 1'b1;
    end
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    checks++; if ({scl_en, sda_en} !== 2'b11) begin errors++; $display("[TB] FAIL rstmid async_release: got %b want 11", {scl_en, sda_en}); end
    repeat (2) begin
      @(posedge clk); #1;
      if (complete === 1'b1 || error === 1'b1) pulse_seen = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    if (complete === 1'b1 || error === 1'b1) pulse_seen = 1'b1;
    checks++; if (pulse_seen) begin errors++; $display("[TB] FAIL rstmid pulse: got 1 want 0"); end
    run_attempt(1225, 1'b0);
    checks++; if (obs_cmp != 1221) begin errors++; $display("[TB] FAIL rstmid fresh_complete: got %0d want 1221", obs_cmp); end
    checks++; if (n_err != 0) begin errors++; $display("[TB] FAIL rstmid error_count: got %0d want 0", n_err); end
  endtask

  task automatic test_held_request;
    int s1, c1, k1, r1, s2, c2, k2, r2;
    clear_schedule();
    // Another device keeps SCL low once the first START has completed.
    add_glitch(1222, 1'b1, MAXC - 1222);
    predict(0, s1, c1, k1, r1);
    predict(k1 + 2, s2, c2, k2, r2);
    run_attempt(r2 + 3, 1'b1);
    checks++; if (obs_cmp != k1) begin errors++; $display("[TB] FAIL held complete: got %0d want %0d", obs_cmp, k1); end
    checks++; if (obs_err != r2) begin errors++; $display("[TB] FAIL held error: got %0d want %0d", obs_err, r2); end
    checks++; if (n_cmp != 1) begin errors++; $display("[TB] FAIL held complete_count: got %0d want 1", n_cmp); end
    checks++; if (n_err != 1) begin errors++; $display("[TB] FAIL held error_count: got %0d want 1", n_err); end
    checks++; if (err_en !== 2'b11) begin errors++; $display("[TB] FAIL held en_at_error: got %b want 11", err_en); end
  endtask

  initial begin
    reset = 1'b1;
    start_flag = 1'b0;
    scl_ext = 1'b1;
    sda_ext = 1'b1;
    clear_schedule();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    $display("[TB] starting protocol_start bench");
    test_reset();
    test_idle_bus();
    test_glitch();
    test_stuck_line();
    test_arbitration();
    test_random_traffic();
    test_reset_mid_operation();
    test_held_request();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/protocol_start.md
# protocol_start

I2C master START-condition generator. It sits directly upstream of the byte-level protocol stages (send/receive byte). On a request from main control it:
- confirms both I2C lines are released for the bus-free time,
- drives SDA low while SCL is high,
- pulls SCL low,
- reports completion.

Main control raises the receive/send-byte start flag only after `complete`. The bus is left owned, with SCL and SDA both driven low.

## Interface
- `CLK_CYCLES`, 500: ref clk cycles per half SCL period; START hold time in cycles.
- `BUS_FREE_CYCLES`, 470: consecutive cycles both lines must read high before START (4.7 us at 100 MHz).
- `TIMEOUT_CYCLES`, 100000: max cycles spent waiting for a free bus before error.

Ports:
- `clk`, in, 1: FPGA reference clock, 100 MHz.
- `reset`, in, 1: asynchronous, active-high.
- `start_flag`, in, 1: request START; sampled only in IDLE.
- `scl_read`, in, 1: value read off the SCL line.
- `sda_read`, in, 1: value read off the SDA line.
- `scl_en`, out, 1: 0 = drive low, 1 = release.
- `sda_en`, out, 1: 0 = drive low, 1 = release.
- `complete`, out, 1: one-cycle pulse, START issued and bus owned.
- `error`, out, 1: one-cycle pulse, bus not free before timeout, or SCL lost during hold.

## Operation
States, 3-bit encoding:
- **IDLE**
  - Clears `complete`/`error` and both counters; `scl_en`/`sda_en` hold their previous value.
  - `start_flag`=1 -> CHECK_BUS.
- **CHECK_BUS**
  - Releases both lines.
  - `free_cnt` increments while `scl_read`&`sda_read`=1 and resets to 0 otherwise.
  - `timeout_cnt` increments every cycle.
  - `free_cnt`==`BUS_FREE_CYCLES`-1 with both lines high -> HOLD_START. This has priority over timeout.
  - Else `timeout_cnt`==`TIMEOUT_CYCLES`-1 -> ERROR.
- **HOLD_START**
  - `sda_en`=0, `scl_en`=1; `clk_counter` counts `CLK_CYCLES`.
  - `scl_read`=0 on any cycle -> ERROR (another master or a stuck line).
  - Count done -> SCL_LOW.
- **SCL_LOW**
  - `scl_en`=0, `sda_en`=0 for `CLK_CYCLES`/2 cycles (integer division) -> DONE.
- **DONE**
  - `complete`=1 for one cycle; SCL and SDA stay driven low -> IDLE.
- **ERROR**
  - `error`=1 for one cycle; `scl_en`=`sda_en`=1 -> IDLE.
- **Undefined encoding** -> IDLE, all outputs at reset values.

Rules:
- Outputs are registered and change on the edge where the state is entered.
- Counter widths: `ceil(log2)` of their respective parameters; no wrap is possible before a terminal compare.
- `start_flag` held high across DONE/ERROR re-triggers CHECK_BUS on the next IDLE cycle.

## Timing
- Reset values: `scl_en`=1, `sda_en`=1, `complete`=0, `error`=0, state IDLE, counters 0.
- Reset mid-operation releases both lines immediately (asynchronous), with no pulse on `complete`/`error`.
- Idle-bus latency: from the `start_flag` sampling edge to `complete` high is 1+`BUS_FREE_CYCLES`+`CLK_CYCLES`+`CLK_CYCLES`/2 edges; 1221 with defaults.
- SDA falling precedes SCL falling by exactly `CLK_CYCLES` cycles, giving tHD;STA = 5 us.
- A single-cycle low glitch on either line in CHECK_BUS restarts the full bus-free window.
- `scl_read`/`sda_read` are already synchronized upstream; no extra synchronizer is used here.

## Structure
- Shared package/include `i2c_pkg` holds:
  - `CLK_CYCLES` and the bus-free/timeout defaults, shared with the byte stages;
  - the drive/release encoding constants.
- State encodings stay local.
- Sub-module `i2c_bus_free_detect` contains `free_cnt`, `timeout_cnt` and their compares, producing `bus_free` and `bus_timeout` pulses. FSM and output registers remain in the top.

## Test plan
- **Idle bus:** lines held high, pulse `start_flag` -> `sda_en` falls 471 cycles later, `scl_en` falls 500 after that, `complete` pulse 250 after that (1221 total); `error` never set.
- **Glitch:** SDA forced low for 1 cycle at CHECK_BUS cycle 300 -> `sda_en` fall delayed to 300+1+470 cycles after CHECK_BUS entry.
- **Stuck line:** SCL held low with `TIMEOUT_CYCLES`=2000 -> `error` pulses after 2000 CHECK_BUS cycles; `complete`=0; both lines released.
- **Arbitration:** `scl_read` driven 0 at HOLD_START cycle 100 -> ERROR next edge; both `en` back to 1.
- **Reset:** `reset` asserted mid-SCL_LOW -> `scl_en`=`sda_en`=1 asynchronously, no pulse; a fresh `start_flag` then completes in 1221 cycles.
- **Held request:** `start_flag` held high -> back-to-back START attempts; second CHECK_BUS sees lines low (bus owned) and times out with `error`.
